regfile_scoreboard: RTL and testbench
=====================================

# regfile_scoreboard

Parametrised multi-read-port register file with write-to-read bypass, optional hardwired zero register, and a per-register busy scoreboard for the pipeline's hazard logic. The decode stage reads operands and reserves destinations at issue. Writeback writes results and releases reservations. It replaces the fixed 32x32, two-read, unreset register file and adds reset, forwarding and hazard tracking.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = register 0 reads as zero, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle writeback data forwarded to read ports

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous, active-low reset
- rd_addr  in  NUM_RD*ADDR_W  read addresses; port i at bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port i at [i*DATA_W +: DATA_W]
- rd_busy  out  NUM_RD  1 = addressed register has an outstanding reservation
- wr_en  in  1  writeback enable
- wr_addr  in  ADDR_W  writeback register
- wr_data  in  DATA_W  writeback data
- iss_en  in  1  reserve destination register
- iss_addr  in  ADDR_W  register to mark busy
- flush  in  1  clear all reservations (pipeline flush)
- busy_cnt  out  ADDR_W+1  number of registers currently busy, registered

## Operation
- State:
  - data array of 2**ADDR_W x DATA_W
  - busy vector of 2**ADDR_W bits
  - busy_cnt register
- Reset (rst_n low, asynchronous): all array entries = 0, busy = 0, busy_cnt = 0. Outputs during reset: rd_data = 0, rd_busy = 0.
- Write: on the edge with wr_en=1, array[wr_addr] <= wr_data and busy[wr_addr] <= 0. Writing a non-busy register is legal and simply updates data.
- Issue: on the edge with iss_en=1, busy[iss_addr] <= 1.
- Priority on the same address in one cycle: issue set beats writeback clear, because the newer producer holds the reservation. The data is still written.
- Flush: on the edge with flush=1, all busy bits are cleared before the issue is applied. flush+iss_en leaves exactly busy[iss_addr]=1. A concurrent wr_en still writes data.
- Zero register (ZERO_REG=1):
  - wr_en/iss_en with address 0 have no effect on data or busy.
  - rd_data for address 0 = 0 and rd_busy = 0, bypass included.
- Read port i, combinational:
  - If BYPASS and wr_en and wr_addr==rd_addr[i] and the address is not the zero register: rd_data[i]=wr_data, rd_busy[i]=0.
  - Else: rd_data[i]=array[rd_addr[i]], rd_busy[i]=busy[rd_addr[i]].
- busy_cnt: updated every edge to the popcount of the next-state busy vector. It never exceeds 2**ADDR_W (or 2**ADDR_W-1 with ZERO_REG).

## Timing
- Read latency 0 (combinational from rd_addr, array, busy, wr_* inputs).
- Write visible:
  - through bypass in the same cycle;
  - through the array from the cycle after the edge;
  - with BYPASS=0, only the following cycle.
- Issue reservation visible on rd_busy from the cycle after the iss_en edge. It is not forwarded in the same cycle.
- busy_cnt lags the busy vector by 0 cycles. Both are registered off the same edge.
- rst_n assertion mid-operation clears everything immediately. The first write or issue after deassertion takes effect on the first rising edge with rst_n=1.
- No throughput limits: one write, one issue and NUM_RD reads every cycle.

## Test plan
- Reset/read:
  - Stimulus: assert rst_n=0 mid-run after writing 0xDEADBEEF to r5, then release.
  - Required: r5 reads 0, all rd_busy=0, busy_cnt=0.
- Bypass:
  - Stimulus: wr_en r7=0x12345678 with rd_addr port0=7 in the same cycle.
  - Required with BYPASS=1: rd_data0=0x12345678 in that cycle.
  - Required with BYPASS=0: old value in that cycle, new value next cycle.
- Scoreboard lifecycle:
  - Stimulus: iss r3, then read r3 the next cycle.
  - Required: rd_busy=1, busy_cnt=1. After wr r3=0xA5, rd_busy=0 the same cycle (bypass) and busy_cnt=0 the next cycle.
- Same-cycle issue+write:
  - Stimulus: r9 is busy; in one cycle, wr r9=0x1 and iss r9.
  - Required: data becomes 0x1, r9 stays busy, busy_cnt unchanged.
- Zero register:
  - Stimulus: wr r0=0xFFFFFFFF and iss r0.
  - Required: r0 reads 0, rd_busy=0, busy_cnt unchanged.
- Flush:
  - Stimulus: reserve r1, r2, r4, then flush+iss r6 in one cycle.
  - Required: busy only on r6, busy_cnt=1. Repeat with NUM_RD=4, DATA_W=64, ADDR_W=4.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Multi-read-port register file with same-cycle writeback bypass, optional
//   hardwired zero register and a per-register busy scoreboard. Decode reads
//   operands and reserves destinations (iss_*); writeback writes results and
//   releases reservations (wr_*). flush drops every reservation.
//   There is no handshake: every port is sampled or produced every cycle.
module regfile_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    input  logic                     flush,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;
    logic [ADDR_W:0]   busy_cnt_q;
    logic [ADDR_W:0]   busy_cnt_d;

    // Writes/issues aimed at the hardwired zero register are dropped here,
    // so neither the array nor the scoreboard ever sees them.
    logic wr_ok;
    logic iss_ok;

    assign wr_ok  = wr_en  && !((ZERO_REG != 0) && (wr_addr  == '0));
    assign iss_ok = iss_en && !((ZERO_REG != 0) && (iss_addr == '0));

    // Next busy vector: flush first, then writeback release, then issue set
    // (issue wins on a shared address since it is the newer producer).
    always_comb begin
        busy_d = busy_q;
        if (flush) begin
            busy_d = '0;
        end
        if (wr_ok) begin
            busy_d[wr_addr] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[iss_addr] = 1'b1;
        end
    end

    // Population count of the next busy vector, registered alongside it.
    always_comb begin
        busy_cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_W{1'b0}}, busy_d[i]};
        end
    end

    // Scoreboard state and its count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Data array; cleared by reset, written by writeback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_ok) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    assign busy_cnt = busy_cnt_q;

    // Read ports: reset and the zero register force zero; otherwise a
    // matching writeback is forwarded (and counts as not busy).
    for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
        logic [ADDR_W-1:0] addr;
        logic              force_zero;
        logic              hit;

        assign addr       = rd_addr[g*ADDR_W +: ADDR_W];
        assign force_zero = !rst_n || ((ZERO_REG != 0) && (addr == '0));
        assign hit        = (BYPASS != 0) && wr_ok && (wr_addr == addr);

        assign rd_data[g*DATA_W +: DATA_W] = force_zero ? '0      :
                                             hit        ? wr_data :
                                                          mem_q[addr];
        assign rd_busy[g] = force_zero ? 1'b0 :
                            hit        ? 1'b0 :
                                         busy_q[addr];
    end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Bench for regfile_scoreboard: a default instance (32x32, 2 ports, zero
// register, bypass) and a wide instance (16x64, 4 ports, no zero register,
// no bypass), both checked against a plain array/flag model.
module tb_regfile_scoreboard;

    localparam int AW_A = 5;
    localparam int DW_A = 32;
    localparam int NR_A = 2;
    localparam int AW_B = 4;
    localparam int DW_B = 64;
    localparam int NR_B = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    logic [NR_A*AW_A-1:0] a_rd_addr;
    logic [NR_A*DW_A-1:0] a_rd_data;
    logic [NR_A-1:0]      a_rd_busy;
    logic                 a_wr_en;
    logic [AW_A-1:0]      a_wr_addr;
    logic [DW_A-1:0]      a_wr_data;
    logic                 a_iss_en;
    logic [AW_A-1:0]      a_iss_addr;
    logic                 a_flush;
    logic [AW_A:0]        a_busy_cnt;

    logic [NR_B*AW_B-1:0] b_rd_addr;
    logic [NR_B*DW_B-1:0] b_rd_data;
    logic [NR_B-1:0]      b_rd_busy;
    logic                 b_wr_en;
    logic [AW_B-1:0]      b_wr_addr;
    logic [DW_B-1:0]      b_wr_data;
    logic                 b_iss_en;
    logic [AW_B-1:0]      b_iss_addr;
    logic                 b_flush;
    logic [AW_B:0]        b_busy_cnt;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: data and reservation flag per register.
    logic [DW_A-1:0] ma_data [32];
    bit              ma_busy [32];
    logic [DW_B-1:0] mb_data [16];
    bit              mb_busy [16];

    regfile_scoreboard #(
        .DATA_W(DW_A), .ADDR_W(AW_A), .NUM_RD(NR_A), .ZERO_REG(1), .BYPASS(1)
    ) dut_a (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
        .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .iss_en(a_iss_en), .iss_addr(a_iss_addr), .flush(a_flush),
        .busy_cnt(a_busy_cnt)
    );

    regfile_scoreboard #(
        .DATA_W(DW_B), .ADDR_W(AW_B), .NUM_RD(NR_B), .ZERO_REG(0), .BYPASS(0)
    ) dut_b (
        .clk(clk), .rst_n(rst_n),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .rd_busy(b_rd_busy),
        .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .iss_en(b_iss_en), .iss_addr(b_iss_addr), .flush(b_flush),
        .busy_cnt(b_busy_cnt)
    );

    function automatic int ma_cnt();
        int c = 0;
        foreach (ma_busy[i]) c += int'(ma_busy[i]);
        return c;
    endfunction

    function automatic int mb_cnt();
        int c = 0;
        foreach (mb_busy[i]) c += int'(mb_busy[i]);
        return c;
    endfunction

    // Expected combinational read values given the current inputs.
    function automatic logic [DW_A-1:0] exp_a_data(logic [AW_A-1:0] ad);
        if (!rst_n || ad == 0) return '0;
        if (a_wr_en && a_wr_addr == ad) return a_wr_data;
        return ma_data[ad];
    endfunction

    function automatic bit exp_a_busy(logic [AW_A-1:0] ad);
        if (!rst_n || ad == 0) return 1'b0;
        if (a_wr_en && a_wr_addr == ad) return 1'b0;
        return ma_busy[ad];
    endfunction

    function automatic logic [DW_B-1:0] exp_b_data(logic [AW_B-1:0] ad);
        if (!rst_n) return '0;
        return mb_data[ad];
    endfunction

    function automatic bit exp_b_busy(logic [AW_B-1:0] ad);
        if (!rst_n) return 1'b0;
        return mb_busy[ad];
    endfunction

    task automatic reset_model();
        foreach (ma_data[i]) begin ma_data[i] = '0; ma_busy[i] = 1'b0; end
        foreach (mb_data[i]) begin mb_data[i] = '0; mb_busy[i] = 1'b0; end
    endtask

    task automatic idle_inputs();
        a_rd_addr = '0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0;
        a_iss_en = 1'b0; a_iss_addr = '0; a_flush = 1'b0;
        b_rd_addr = '0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0;
        b_iss_en = 1'b0; b_iss_addr = '0; b_flush = 1'b0;
    endtask

    // One rising edge: update the model from the held inputs, then return
    // just after the falling edge with inputs idle.
    task automatic clock_edge();
        @(posedge clk);
        if (rst_n) begin
            if (a_flush) foreach (ma_busy[i]) ma_busy[i] = 1'b0;
            if (a_wr_en && a_wr_addr != 0) begin
                ma_data[a_wr_addr] = a_wr_data;
                ma_busy[a_wr_addr] = 1'b0;
            end
            if (a_iss_en && a_iss_addr != 0) ma_busy[a_iss_addr] = 1'b1;
            if (b_flush) foreach (mb_busy[i]) mb_busy[i] = 1'b0;
            if (b_wr_en) begin
                mb_data[b_wr_addr] = b_wr_data;
                mb_busy[b_wr_addr] = 1'b0;
            end
            if (b_iss_en) mb_busy[b_iss_addr] = 1'b1;
        end
        @(negedge clk);
        #1;
        idle_inputs();
        #1;
    endtask

    task automatic test_reset();
        // Outputs straight out of reset.
        for (int p = 0; p < NR_A; p++) begin
            a_rd_addr[p*AW_A +: AW_A] = AW_A'($urandom_range(1, 31));
        end
        #1;
        vectors++;
        if (a_rd_data !== '0 || a_rd_busy !== '0 || a_busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_a: data=%h busy=%b cnt=%0d required 0/0/0", a_rd_data, a_rd_busy, a_busy_cnt);
        end
        vectors++;
        if (b_rd_data !== '0 || b_rd_busy !== '0 || b_busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL reset_b: data=%h busy=%b cnt=%0d required 0/0/0", b_rd_data, b_rd_busy, b_busy_cnt);
        end
        // Write r5, reserve r8, then reset in the middle of a cycle.
        a_wr_en = 1'b1; a_wr_addr = 5'd5; a_wr_data = 32'hDEADBEEF;
        a_iss_en = 1'b1; a_iss_addr = 5'd8;
        b_wr_en = 1'b1; b_wr_addr = 4'd5; b_wr_data = 64'hDEADBEEF;
        clock_edge();
        a_rd_addr[0 +: AW_A] = 5'd5;
        #1;
        vectors++;
        if (a_rd_data[0 +: DW_A] !== 32'hDEADBEEF || a_busy_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL pre_reset_r5: data=%h cnt=%0d required deadbeef/1", a_rd_data[0 +: DW_A], a_busy_cnt);
        end
        rst_n = 1'b0;
        reset_model();
        #1;
        vectors++;
        if (a_rd_data[0 +: DW_A] !== '0 || a_busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL async_reset: data=%h cnt=%0d required 0/0", a_rd_data[0 +: DW_A], a_busy_cnt);
        end
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        a_rd_addr[0 +: AW_A] = 5'd5; a_rd_addr[AW_A +: AW_A] = 5'd8;
        b_rd_addr[0 +: AW_B] = 4'd5;
        #1;
        vectors++;
        if (a_rd_data !== '0 || a_rd_busy !== '0 || a_busy_cnt !== '0) begin
            miscompares++;
            $display("FAIL post_reset_a: data=%h busy=%b cnt=%0d required 0/0/0", a_rd_data, a_rd_busy, a_busy_cnt);
        end
        vectors++;
        if (b_rd_data[0 +: DW_B] !== '0) begin
            miscompares++;
            $display("FAIL post_reset_b: data=%h required 0", b_rd_data[0 +: DW_B]);
        end
    endtask

    task automatic test_bypass();
        // Give r7 of the no-bypass instance an old value first.
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 64'h1111;
        clock_edge();
        a_wr_en = 1'b1; a_wr_addr = 5'd7; a_wr_data = 32'h12345678;
        a_rd_addr[0 +: AW_A] = 5'd7;
        b_wr_en = 1'b1; b_wr_addr = 4'd7; b_wr_data = 64'h12345678;
        b_rd_addr[0 +: AW_B] = 4'd7;
        #1;
        vectors++;
        if (a_rd_data[0 +: DW_A] !== 32'h12345678) begin
            miscompares++;
            $display("FAIL bypass_same_cycle: got %h required 12345678", a_rd_data[0 +: DW_A]);
        end
        vectors++;
        if (b_rd_data[0 +: DW_B] !== 64'h1111) begin
            miscompares++;
            $display("FAIL nobypass_same_cycle: got %h required 1111", b_rd_data[0 +: DW_B]);
        end
        clock_edge();
        b_rd_addr[0 +: AW_B] = 4'd7;
        #1;
        vectors++;
        if (b_rd_data[0 +: DW_B] !== 64'h12345678) begin
            miscompares++;
            $display("FAIL nobypass_next_cycle: got %h required 12345678", b_rd_data[0 +: DW_B]);
        end
    endtask

    task automatic test_scoreboard();
        a_iss_en = 1'b1; a_iss_addr = 5'd3;
        clock_edge();
        a_rd_addr[0 +: AW_A] = 5'd3;
        #1;
        vectors++;
        if (a_rd_busy[0] !== 1'b1 || a_busy_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL sb_reserved: busy=%b cnt=%0d required 1/1", a_rd_busy[0], a_busy_cnt);
        end
        a_wr_en = 1'b1; a_wr_addr = 5'd3; a_wr_data = 32'hA5;
        #1;
        vectors++;
        if (a_rd_busy[0] !== 1'b0 || a_rd_data[0 +: DW_A] !== 32'hA5) begin
            miscompares++;
            $display("FAIL sb_release_bypass: busy=%b data=%h required 0/a5", a_rd_busy[0], a_rd_data[0 +: DW_A]);
        end
        clock_edge();
        a_rd_addr[0 +: AW_A] = 5'd3;
        #1;
        vectors++;
        if (a_busy_cnt !== 6'd0 || a_rd_busy[0] !== 1'b0 || a_rd_data[0 +: DW_A] !== 32'hA5) begin
            miscompares++;
            $display("FAIL sb_released: cnt=%0d busy=%b data=%h required 0/0/a5", a_busy_cnt, a_rd_busy[0], a_rd_data[0 +: DW_A]);
        end
    endtask

    task automatic test_issue_write();
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        clock_edge();
        a_wr_en = 1'b1; a_wr_addr = 5'd9; a_wr_data = 32'h1;
        a_iss_en = 1'b1; a_iss_addr = 5'd9;
        clock_edge();
        a_rd_addr[AW_A +: AW_A] = 5'd9;
        #1;
        vectors++;
        if (a_rd_data[DW_A +: DW_A] !== 32'h1 || a_rd_busy[1] !== 1'b1 || a_busy_cnt !== 6'd1) begin
            miscompares++;
            $display("FAIL issue_beats_write: data=%h busy=%b cnt=%0d required 1/1/1", a_rd_data[DW_A +: DW_A], a_rd_busy[1], a_busy_cnt);
        end
    endtask

    task automatic test_zero_reg();
        logic [AW_A:0] cnt_before;
        cnt_before = a_busy_cnt;
        a_wr_en = 1'b1; a_wr_addr = 5'd0; a_wr_data = 32'hFFFFFFFF;
        a_iss_en = 1'b1; a_iss_addr = 5'd0;
        a_rd_addr[AW_A +: AW_A] = 5'd0;
        b_wr_en = 1'b1; b_wr_addr = 4'd0; b_wr_data = 64'hFFFF_0000_FFFF_0000;
        b_iss_en = 1'b1; b_iss_addr = 4'd0;
        #1;
        vectors++;
        if (a_rd_data[DW_A +: DW_A] !== '0 || a_rd_busy[1] !== 1'b0) begin
            miscompares++;
            $display("FAIL zero_same_cycle: data=%h busy=%b required 0/0", a_rd_data[DW_A +: DW_A], a_rd_busy[1]);
        end
        clock_edge();
        a_rd_addr[AW_A +: AW_A] = 5'd0;
        b_rd_addr[3*AW_B +: AW_B] = 4'd0;
        #1;
        vectors++;
        if (a_rd_data[DW_A +: DW_A] !== '0 || a_rd_busy[1] !== 1'b0 || a_busy_cnt !== cnt_before) begin
            miscompares++;
            $display("FAIL zero_after: data=%h busy=%b cnt=%0d required 0/0/%0d", a_rd_data[DW_A +: DW_A], a_rd_busy[1], a_busy_cnt, cnt_before);
        end
        // Without a zero register, r0 is an ordinary register.
        vectors++;
        if (b_rd_data[3*DW_B +: DW_B] !== 64'hFFFF_0000_FFFF_0000 || b_rd_busy[3] !== 1'b1) begin
            miscompares++;
            $display("FAIL r0_plain: data=%h busy=%b required ffff0000ffff0000/1", b_rd_data[3*DW_B +: DW_B], b_rd_busy[3]);
        end
    endtask

    task automatic test_flush();
        int reg_list[3] = '{1, 2, 4};
        foreach (reg_list[k]) begin
            a_iss_en = 1'b1; a_iss_addr = AW_A'(reg_list[k]);
            b_iss_en = 1'b1; b_iss_addr = AW_B'(reg_list[k]);
            clock_edge();
        end
        vectors++;
        if (a_busy_cnt !== AW_A'(ma_cnt()) + 6'd0 || b_busy_cnt !== 5'(mb_cnt())) begin
            miscompares++;
            $display("FAIL pre_flush_cnt: a=%0d b=%0d required %0d/%0d", a_busy_cnt, b_busy_cnt, ma_cnt(), mb_cnt());
        end
        a_flush = 1'b1; a_iss_en = 1'b1; a_iss_addr = 5'd6;
        b_flush = 1'b1; b_iss_en = 1'b1; b_iss_addr = 4'd6;
        clock_edge();
        vectors++;
        if (a_busy_cnt !== 6'd1 || b_busy_cnt !== 5'd1) begin
            miscompares++;
            $display("FAIL flush_cnt: a=%0d b=%0d required 1/1", a_busy_cnt, b_busy_cnt);
        end
        for (int r = 0; r < 32; r++) begin
            a_rd_addr[0 +: AW_A] = AW_A'(r);
            #1;
            vectors++;
            if (a_rd_busy[0] !== (r == 6)) begin
                miscompares++;
                $display("FAIL flush_busy_a r%0d: got %b required %b", r, a_rd_busy[0], (r == 6));
            end
        end
        b_rd_addr = {4'd6, 4'd4, 4'd2, 4'd1};
        #1;
        vectors++;
        if (b_rd_busy !== 4'b1000) begin
            miscompares++;
            $display("FAIL flush_busy_b: got %b required 1000", b_rd_busy);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            a_wr_en = 1'($urandom_range(0, 1));
            a_wr_addr = AW_A'($urandom_range(0, 31));
            a_wr_data = $urandom;
            a_iss_en = 1'($urandom_range(0, 1));
            a_iss_addr = AW_A'($urandom_range(0, 31));
            a_flush = ($urandom_range(0, 15) == 0);
            b_wr_en = 1'($urandom_range(0, 1));
            b_wr_addr = AW_B'($urandom_range(0, 15));
            b_wr_data = {$urandom, $urandom};
            b_iss_en = 1'($urandom_range(0, 1));
            b_iss_addr = AW_B'($urandom_range(0, 15));
            b_flush = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NR_A; p++) begin
                // Bias port 0 toward the write address to exercise bypass.
                a_rd_addr[p*AW_A +: AW_A] = (p == 0 && $urandom_range(0, 2) == 0) ?
                    a_wr_addr : AW_A'($urandom_range(0, 31));
            end
            for (int p = 0; p < NR_B; p++) begin
                b_rd_addr[p*AW_B +: AW_B] = AW_B'($urandom_range(0, 15));
            end
            #1;
            for (int p = 0; p < NR_A; p++) begin
                vectors++;
                if (a_rd_data[p*DW_A +: DW_A] !== exp_a_data(a_rd_addr[p*AW_A +: AW_A]) ||
                    a_rd_busy[p] !== exp_a_busy(a_rd_addr[p*AW_A +: AW_A])) begin
                    miscompares++;
                    $display("FAIL rand_read_a n=%0d p=%0d: data=%h busy=%b required %h/%b", n, p,
                             a_rd_data[p*DW_A +: DW_A], a_rd_busy[p],
                             exp_a_data(a_rd_addr[p*AW_A +: AW_A]), exp_a_busy(a_rd_addr[p*AW_A +: AW_A]));
                end
            end
            for (int p = 0; p < NR_B; p++) begin
                vectors++;
                if (b_rd_data[p*DW_B +: DW_B] !== exp_b_data(b_rd_addr[p*AW_B +: AW_B]) ||
                    b_rd_busy[p] !== exp_b_busy(b_rd_addr[p*AW_B +: AW_B])) begin
                    miscompares++;
                    $display("FAIL rand_read_b n=%0d p=%0d: data=%h busy=%b required %h/%b", n, p,
                             b_rd_data[p*DW_B +: DW_B], b_rd_busy[p],
                             exp_b_data(b_rd_addr[p*AW_B +: AW_B]), exp_b_busy(b_rd_addr[p*AW_B +: AW_B]));
                end
            end
            clock_edge();
            vectors++;
            if (a_busy_cnt !== 6'(ma_cnt()) || b_busy_cnt !== 5'(mb_cnt())) begin
                miscompares++;
                $display("FAIL rand_cnt n=%0d: a=%0d b=%0d required %0d/%0d", n, a_busy_cnt, b_busy_cnt, ma_cnt(), mb_cnt());
            end
        end
    endtask

    initial begin
        idle_inputs();
        reset_model();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        test_reset();
        test_bypass();
        test_scoreboard();
        test_issue_write();
        test_zero_reg();
        test_flush();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
